// File: rtl/sdram_csr_bank_if.sv
// Wishbone slave bus bundle for the CSR bank: byte address, write data,
// byte lanes and the strobe/cycle/write qualifiers, with registered
// read data and a one-cycle ack returned by the slave.
interface sdram_csr_bank_if #(
  parameter int AW = 16
);
  logic [AW-1:0] wbs_address;
  logic [31:0]   wbs_writedata;
  logic [3:0]    wbs_sel;
  logic          wbs_strobe;
  logic          wbs_cycle;
  logic          wbs_write;
  logic [31:0]   wbs_readdata;
  logic          wbs_ack;

  modport master (
    output wbs_address, wbs_writedata, wbs_sel, wbs_strobe, wbs_cycle, wbs_write,
    input  wbs_readdata, wbs_ack
  );

  modport slave (
    input  wbs_address, wbs_writedata, wbs_sel, wbs_strobe, wbs_cycle, wbs_write,
    output wbs_readdata, wbs_ack
  );
endinterface

// File: rtl/sdram_csr_bank.sv
// CSR bank for the SDRAM controller and sibling peripherals.
// Word map: 0 CTRL, 1 IRQ_STATUS (W1C), 2 IRQ_MASK, then NUM_RO read-only
// status words, then NUM_RW byte-writable config words. Unmapped words
// read 0, ignore writes and still ack. Every access acks one cycle after
// accept; a held strobe therefore yields a transfer every other cycle.
module sdram_csr_bank #(
  parameter int                   AW       = 16,
  parameter int                   NUM_RW   = 8,
  parameter int                   NUM_RO   = 2,
  parameter int                   NUM_EVT  = 4,
  parameter logic [31:0]          SC_MASK  = 32'h0000_0001,
  parameter logic [31:0]          CTRL_RST = 32'h0,
  parameter logic [NUM_RW*32-1:0] RW_RST   = {NUM_RW{32'h0}}
) (
  input  logic                                 clk,
  input  logic                                 reset,
  sdram_csr_bank_if.slave                      wbs,
  output logic [31:0]                          ctrl_level,
  output logic [31:0]                          ctrl_pulse,
  input  logic [NUM_EVT-1:0]                   evt_in,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] status_in,
  output logic [NUM_RW*32-1:0]                 csr_rw,
  output logic                                 irq
);

  localparam logic [31:0] RO_BASE = 32'd3;
  localparam logic [31:0] RW_BASE = 32'(3 + NUM_RO);
  localparam logic [31:0] RW_END  = 32'(3 + NUM_RO + NUM_RW);

  // Replace only the byte lanes selected by lane_mask.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] lane_mask);
    return (old_val & ~lane_mask) | (new_val & lane_mask);
  endfunction

  logic               ack_p1;
  logic [31:0]        rdata_p1;
  logic [31:0]        ctrl_q;
  logic [NUM_EVT-1:0] irq_status;
  logic [NUM_EVT-1:0] irq_mask;
  logic [31:0]        rw_q [NUM_RW];

  logic               accept;
  logic               wr_acc;
  logic               rd_acc;
  logic [31:0]        idx32;
  logic [31:0]        ro_off;
  logic [31:0]        rw_off;
  logic [31:0]        wmask;
  logic [31:0]        wdata_m;
  logic               hit_ctrl;
  logic               hit_sts;
  logic               hit_msk;
  logic               hit_ro;
  logic               hit_rw;
  logic [31:0]        rd_val;
  logic [31:0]        ctrl_next;
  logic [31:0]        mask_next;
  logic [NUM_EVT-1:0] clr_evt;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^wbs.wbs_address[1:0];

  // Handshake qualification, address decode and write-side merge values.
  always_comb begin
    accept    = wbs.wbs_cycle & wbs.wbs_strobe & ~ack_p1;
    wr_acc    = accept & wbs.wbs_write;
    rd_acc    = accept & ~wbs.wbs_write;
    idx32     = 32'(wbs.wbs_address[AW-1:2]);
    ro_off    = idx32 - RO_BASE;
    rw_off    = idx32 - RW_BASE;
    wmask     = {{8{wbs.wbs_sel[3]}}, {8{wbs.wbs_sel[2]}},
                 {8{wbs.wbs_sel[1]}}, {8{wbs.wbs_sel[0]}}};
    wdata_m   = wbs.wbs_writedata & wmask;
    hit_ctrl  = (idx32 == 32'd0);
    hit_sts   = (idx32 == 32'd1);
    hit_msk   = (idx32 == 32'd2);
    hit_ro    = (idx32 >= RO_BASE) && (idx32 < RW_BASE);
    hit_rw    = (idx32 >= RW_BASE) && (idx32 < RW_END);
    ctrl_next = lane_merge(ctrl_q, wbs.wbs_writedata, wmask) & ~SC_MASK;
    mask_next = lane_merge(32'(irq_mask), wbs.wbs_writedata, wmask);
    clr_evt   = (wr_acc && hit_sts) ? wdata_m[NUM_EVT-1:0] : '0;
  end

  // Read mux; SC bits are never stored in ctrl_q so they read back 0.
  always_comb begin
    rd_val = 32'h0;
    if (hit_ctrl) rd_val = ctrl_q;
    if (hit_sts)  rd_val = 32'(irq_status);
    if (hit_msk)  rd_val = 32'(irq_mask);
    for (int k = 0; k < NUM_RO; k++) begin
      if (hit_ro && (ro_off == 32'(k))) rd_val = status_in[k*32 +: 32];
    end
    for (int k = 0; k < NUM_RW; k++) begin
      if (hit_rw && (rw_off == 32'(k))) rd_val = rw_q[k];
    end
  end

  // Stage p1: ack, read data, control, interrupt state and the irq line.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_p1     <= 1'b0;
      rdata_p1   <= 32'h0;
      ctrl_q     <= CTRL_RST & ~SC_MASK;
      ctrl_pulse <= 32'h0;
      irq_status <= '0;
      irq_mask   <= '0;
      irq        <= 1'b0;
    end else begin
      ack_p1     <= accept;
      ctrl_pulse <= 32'h0;
      if (rd_acc) rdata_p1 <= rd_val;
      if (wr_acc && hit_ctrl) begin
        ctrl_q     <= ctrl_next;
        ctrl_pulse <= wdata_m & SC_MASK;
      end
      if (wr_acc && hit_msk) irq_mask <= mask_next[NUM_EVT-1:0];
      // A clear and a new event on the same bit leave the bit set.
      irq_status <= (irq_status & ~clr_evt) | evt_in;
      irq        <= |(irq_status & irq_mask);
    end
  end

  // Stage p1: configuration registers with byte-lane writes.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_RW; k++) begin
      if (reset) begin
        rw_q[k] <= RW_RST[k*32 +: 32];
      end else if (wr_acc && hit_rw && (rw_off == 32'(k))) begin
        rw_q[k] <= lane_merge(rw_q[k], wbs.wbs_writedata, wmask);
      end
    end
  end

  assign wbs.wbs_ack      = ack_p1;
  assign wbs.wbs_readdata = rdata_p1;
  assign ctrl_level       = ctrl_q;

  for (genvar g = 0; g < NUM_RW; g++) begin : g_flat
    assign csr_rw[g*32 +: 32] = rw_q[g];
  end

endmodule
